// File: rtl/wb_arbiter_if.sv
// Writeback request/grant bundle between three execution units and the
// register-file write port of wb_arbiter.
interface wb_arbiter_if;
    logic        alu_valid, lsu_valid, mdu_valid;
    logic [4:0]  alu_rd, lsu_rd, mdu_rd;
    logic [31:0] alu_data, lsu_data, mdu_data;
    logic        alu_ready, lsu_ready, mdu_ready;
    logic [4:0]  rf_rd;
    logic [31:0] rf_result;
    logic        rf_reg_write;
    logic [31:0] pending_mask;

    modport master (
        output alu_valid, lsu_valid, mdu_valid,
        output alu_rd, lsu_rd, mdu_rd,
        output alu_data, lsu_data, mdu_data,
        input  alu_ready, lsu_ready, mdu_ready,
        input  rf_rd, rf_result, rf_reg_write, pending_mask
    );

    modport slave (
        input  alu_valid, lsu_valid, mdu_valid,
        input  alu_rd, lsu_rd, mdu_rd,
        input  alu_data, lsu_data, mdu_data,
        output alu_ready, lsu_ready, mdu_ready,
        output rf_rd, rf_result, rf_reg_write, pending_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// Three-way writeback arbiter: fixed priority LSU > MDU > ALU with
// starvation promotion, single registered register-file write per cycle.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic        clk,
    input logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int N = 3;

    // Lane 0 has the highest base priority, so "lowest set bit" picks the winner.
    logic [N-1:0]           valid, urgent, grant;
    logic [N-1:0][4:0]      rd;
    logic [N-1:0][31:0]     data;
    logic [N-1:0][2:0]      wait_cnt;
    logic [4:0]             sel_rd;
    logic [31:0]            sel_data;
    logic [31:0]            pend;

    assign valid = {bus.alu_valid, bus.mdu_valid, bus.lsu_valid};
    assign rd    = {bus.alu_rd,    bus.mdu_rd,    bus.lsu_rd};
    assign data  = {bus.alu_data,  bus.mdu_data,  bus.lsu_data};

    always_comb begin
        urgent = '0;
        for (int i = 0; i < N; i++)
            urgent[i] = valid[i] && (wait_cnt[i] >= 3'(STARVE_LIMIT));
    end

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (|urgent) grant = urgent & (~urgent + N'(1));
            else         grant = valid  & (~valid  + N'(1));
        end
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        pend     = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_rd   = rd[i];
                sel_data = data[i];
            end
            if (valid[i] && !grant[i]) pend[rd[i]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign bus.lsu_ready    = grant[0];
    assign bus.mdu_ready    = grant[1];
    assign bus.alu_ready    = grant[2];
    assign bus.pending_mask = pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt         <= '0;
            bus.rf_reg_write <= 1'b0;
            bus.rf_rd        <= '0;
            bus.rf_result    <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] || grant[i])  wait_cnt[i] <= 3'd0;
                else if (wait_cnt[i] != 3'd7) wait_cnt[i] <= wait_cnt[i] + 3'd1;
            end
            // A granted rd==0 request is swallowed: the write port stays idle.
            if (|grant && sel_rd != 5'd0) begin
                bus.rf_reg_write <= 1'b1;
                bus.rf_rd        <= sel_rd;
                bus.rf_result    <= sel_data;
            end else begin
                bus.rf_reg_write <= 1'b0;
                bus.rf_rd        <= '0;
                bus.rf_result    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter: a timestamp-based reference
// model predicts grants, pending_mask and the next-cycle register-file write.
module tb_wb_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Requester index: 0 = LSU, 1 = MDU, 2 = ALU.
    logic        v   [3];
    logic [4:0]  rdv [3];
    logic [31:0] dat [3];
    logic        acc [3];
    int          prob[3];
    int          rd_max;

    assign bus.lsu_valid = v[0];  assign bus.lsu_rd = rdv[0];  assign bus.lsu_data = dat[0];
    assign bus.mdu_valid = v[1];  assign bus.mdu_rd = rdv[1];  assign bus.mdu_data = dat[1];
    assign bus.alu_valid = v[2];  assign bus.alu_rd = rdv[2];  assign bus.alu_data = dat[2];

    // Requester-side protocol: an unaccepted request stays put.
    a_lsu: assert property (@(posedge clk) disable iff (rst)
        (bus.lsu_valid && !bus.lsu_ready) |=> (bus.lsu_valid && $stable(bus.lsu_rd) && $stable(bus.lsu_data)));
    a_mdu: assert property (@(posedge clk) disable iff (rst)
        (bus.mdu_valid && !bus.mdu_ready) |=> (bus.mdu_valid && $stable(bus.mdu_rd) && $stable(bus.mdu_data)));
    a_alu: assert property (@(posedge clk) disable iff (rst)
        (bus.alu_valid && !bus.alu_ready) |=> (bus.alu_valid && $stable(bus.alu_rd) && $stable(bus.alu_data)));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: each requester remembers the cycle its current wait began.
    int cyc = 0;
    int start [3];
    int w, score, best, eg;
    logic [2:0]  exp_r, dut_r;
    logic [31:0] exp_pm;

    initial for (int i = 0; i < 3; i++) begin
        start[i] = 0; v[i] = 1'b0; rdv[i] = '0; dat[i] = '0; acc[i] = 1'b0; prob[i] = 0;
    end

    always @(negedge clk) begin
        eg = -1; best = -1;
        for (int i = 0; i < 3; i++) begin
            if (v[i] && !rst) begin
                w = cyc - start[i];
                if (w > 7) w = 7;
                score = ((w >= LIMIT) ? 10 : 0) + (2 - i);
                if (score > best) begin best = score; eg = i; end
            end
        end
        exp_r  = '0;
        exp_pm = '0;
        for (int i = 0; i < 3; i++) begin
            if (eg == i) exp_r[i] = 1'b1;
            else if (v[i] && rdv[i] != 5'd0) exp_pm[rdv[i]] = 1'b1;
        end
        dut_r = {bus.alu_ready, bus.mdu_ready, bus.lsu_ready};
        n_cmp++;
        if (dut_r !== exp_r) begin
            n_err++;
            $display("FAIL ready cyc=%0d got=%b exp=%b (alu,mdu,lsu)", cyc, dut_r, exp_r);
        end
        n_cmp++;
        if (bus.pending_mask !== exp_pm) begin
            n_err++;
            $display("FAIL pending_mask cyc=%0d got=%h exp=%h", cyc, bus.pending_mask, exp_pm);
        end
        if (eg >= 0 && rdv[eg] != 5'd0) exp_q.push_back({1'b1, rdv[eg], dat[eg]});
        else                            exp_q.push_back('0);
        for (int i = 0; i < 3; i++) begin
            acc[i] = dut_r[i] && v[i];
            if (rst || !v[i] || eg == i) start[i] = cyc + 1;
        end
        cyc++;
    end

    // Monitor: the registered write port reflects the previous cycle's grant.
    wr_t e;
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.rf_reg_write !== e.we || bus.rf_rd !== e.rd || bus.rf_result !== e.data) begin
                n_err++;
                $display("FAIL rf_write got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                         bus.rf_reg_write, bus.rf_rd, bus.rf_result, e.we, e.rd, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) v[i] = 1'b0;
            if (!v[i] && int'($urandom_range(0, 99)) < prob[i]) begin
                v[i]   = 1'b1;
                rdv[i] = 5'($urandom_range(0, rd_max));
                dat[i] = $urandom;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        rd_max = 31;
        run(3);
        rst = 1'b0;

        // Lone ALU write
        v[2] = 1'b1; rdv[2] = 5'd5; dat[2] = 32'hDEADBEEF;
        run(3);

        // Same rd from LSU and ALU: LSU first, ALU value lands last
        v[0] = 1'b1; rdv[0] = 5'd3; dat[0] = 32'h1111_0000;
        v[2] = 1'b1; rdv[2] = 5'd3; dat[2] = 32'h2222_0000;
        run(3);

        // rd==0 is granted and dropped
        v[1] = 1'b1; rdv[1] = 5'd0; dat[1] = 32'hCAFE_F00D;
        run(2);

        // LSU flood starves ALU until its wait reaches the limit
        prob[0] = 100; rd_max = 31;
        v[2] = 1'b1; rdv[2] = 5'd9; dat[2] = 32'h0A1B_2C3D;
        run(8);
        prob[0] = 0;
        run(4);

        // Reset pulse with all three requesting
        prob[0] = 100; prob[1] = 100; prob[2] = 100;
        run(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(6);

        // Randomized traffic with small rd range for collisions and rare resets
        prob[0] = 50; prob[1] = 40; prob[2] = 60; rd_max = 7;
        for (int k = 0; k < 2000; k++) begin
            step();
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
        prob[0] = 0; prob[1] = 0; prob[2] = 0;
        run(12);
        repeat (2) @(posedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
